// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared size/state encodings and lane helpers for the MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Size code 2'b11 falls through to the word behaviour everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return (lo != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic sext);
        logic [31:0] sh;
        case (size)
            SZ_BYTE: begin
                sh = word >> {lo, 3'b000};
                return sext ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
            end
            SZ_HALF: begin
                sh = word >> {lo[1], 4'b0000};
                return sext ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            end
            default: return word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Word array with byte-enable synchronous write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 Clk,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [3:0]           i_be,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata
);
    localparam int c_DEPTH = 1 << ADDR_BITS;

    logic [31:0] r_mem [c_DEPTH];

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM pipeline stage with multi-cycle memory access and MEM/WB regs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] m_currPC,
    input  logic [31:0] m_instruction,
    input  logic        m_memRead,
    input  logic        m_memWrite,
    input  logic [1:0]  m_size,
    input  logic        m_signExt,
    input  logic        m_writeBack,
    input  logic [4:0]  m_writeReg,
    input  logic [31:0] m_ALUresult,
    input  logic [31:0] m_data2,
    output logic        stall,
    output logic [31:0] w_currPC,
    output logic [31:0] w_instruction,
    output logic [31:0] w_ALUresult,
    output logic [31:0] w_readData,
    output logic        w_writeBack,
    output logic [4:0]  w_writeReg,
    output logic        w_misaligned
);
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        w_is_mem, w_req_misaligned, w_start, w_access;
    logic [31:0] r_addr, r_data, r_pc, r_instr;
    logic [1:0]  r_size;
    logic        r_signext, r_read, r_write, r_wb;
    logic [4:0]  r_wreg;
    logic [3:0]  w_be;
    logic [31:0] w_rdata;

    assign w_is_mem         = m_memRead | m_memWrite;
    assign w_req_misaligned = w_is_mem & is_misaligned(m_size, m_ALUresult[1:0]);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        stall        = 1'b0;
        w_start      = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_mem && !w_req_misaligned) begin
                    stall        = 1'b1;
                    w_start      = 1'b1;
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt != 4'd0) begin
                    stall      = 1'b1;
                    w_cnt_next = r_cnt - 4'd1;
                end else begin
                    w_access     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (Rst) begin
            stall = 1'b0;
        end
    end

    // Upstream holds m_* while stalled, but only the captured copy is trusted in BUSY.
    always_ff @(posedge Clk) begin
        if (w_start) begin
            r_addr    <= m_ALUresult;
            r_data    <= m_data2;
            r_size    <= m_size;
            r_signext <= m_signExt;
            r_read    <= m_memRead;
            r_write   <= m_memWrite;
            r_wb      <= m_writeBack;
            r_wreg    <= m_writeReg;
            r_pc      <= m_currPC;
            r_instr   <= m_instruction;
        end
    end

    // Reset gates the write so an aborted store never lands.
    assign w_be = (w_access && r_write && !Rst) ? byte_enables(r_size, r_addr[1:0]) : 4'b0000;

    data_memory #(
        .ADDR_BITS (ADDR_BITS)
    ) u_data_memory (
        .Clk     (Clk),
        .i_addr  (r_addr[ADDR_BITS+1:2]),
        .i_be    (w_be),
        .i_wdata (store_lanes(r_size, r_data)),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            w_currPC      <= 32'd0;
            w_instruction <= 32'd0;
            w_ALUresult   <= 32'd0;
            w_readData    <= 32'd0;
            w_writeBack   <= 1'b0;
            w_writeReg    <= 5'd0;
            w_misaligned  <= 1'b0;
        end else begin
            w_misaligned <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_is_mem || w_req_misaligned) begin
                        w_currPC      <= m_currPC;
                        w_instruction <= m_instruction;
                        w_ALUresult   <= m_ALUresult;
                        w_writeReg    <= m_writeReg;
                        w_readData    <= 32'd0;
                        w_writeBack   <= m_writeBack & ~w_req_misaligned;
                        w_misaligned  <= w_req_misaligned;
                    end else begin
                        w_writeBack <= 1'b0;
                    end
                end
                BUSY: begin
                    if (!w_access) begin
                        w_writeBack <= 1'b0;
                    end else begin
                        w_currPC      <= r_pc;
                        w_instruction <= r_instr;
                        w_ALUresult   <= r_addr;
                        w_writeReg    <= r_wreg;
                        w_writeBack   <= r_wb;
                        w_readData    <= (r_read && !r_write) ?
                                         load_format(w_rdata, r_size, r_addr[1:0], r_signext) : 32'd0;
                    end
                end
                default: w_writeBack <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a byte-array memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    localparam int AB  = 4;
    localparam int LAT = 2;
    localparam int NB  = 4 * (1 << AB);

    logic        Clk, Rst;
    logic [31:0] m_currPC, m_instruction, m_ALUresult, m_data2;
    logic        m_memRead, m_memWrite, m_signExt, m_writeBack;
    logic [1:0]  m_size;
    logic [4:0]  m_writeReg;
    logic        stall;
    logic [31:0] w_currPC, w_instruction, w_ALUresult, w_readData;
    logic        w_writeBack, w_misaligned;
    logic [4:0]  w_writeReg;

    mem_access_unit #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .Clk(Clk), .Rst(Rst),
        .m_currPC(m_currPC), .m_instruction(m_instruction),
        .m_memRead(m_memRead), .m_memWrite(m_memWrite), .m_size(m_size),
        .m_signExt(m_signExt), .m_writeBack(m_writeBack), .m_writeReg(m_writeReg),
        .m_ALUresult(m_ALUresult), .m_data2(m_data2),
        .stall(stall),
        .w_currPC(w_currPC), .w_instruction(w_instruction), .w_ALUresult(w_ALUresult),
        .w_readData(w_readData), .w_writeBack(w_writeBack), .w_writeReg(w_writeReg),
        .w_misaligned(w_misaligned)
    );

    typedef struct {
        int          due;
        logic [31:0] pc, instr, alu, rdata;
        logic        wb;
        logic [4:0]  wreg;
        logic        mis;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic       rst_q = 1'b1;
    bit         started = 1'b0;
    logic [7:0] mdl [NB];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc   <= cyc + 1;
        rst_q <= Rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on the cycle each result is due.
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (started) begin
            if (rst_q) begin
                check("reset_w_fields", w_currPC | w_instruction | w_ALUresult | w_readData |
                      {25'd0, w_writeBack, w_writeReg} | {31'd0, w_misaligned}, 32'd0);
                if (Rst) check("reset_stall", {31'd0, stall}, 32'd0);
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check("due_cycle",     cyc, e.due);
                check("w_currPC",      w_currPC, e.pc);
                check("w_instruction", w_instruction, e.instr);
                check("w_ALUresult",   w_ALUresult, e.alu);
                check("w_readData",    w_readData, e.rdata);
                check("w_writeBack",   {31'd0, w_writeBack}, {31'd0, e.wb});
                check("w_writeReg",    {27'd0, w_writeReg}, {27'd0, e.wreg});
                check("w_misaligned",  {31'd0, w_misaligned}, {31'd0, e.mis});
            end else begin
                check("bubble_misaligned", {31'd0, w_misaligned}, 32'd0);
                check("bubble_writeBack",  {31'd0, w_writeBack}, 32'd0);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                         input logic wb, input logic [4:0] wreg, input logic [31:0] alu,
                         input logic [31:0] d2);
        exp_t        e;
        int          nb, base, ns, n;
        logic [1:0]  s;
        logic [31:0] v;
        logic        mem, mis;
        s   = (sz == 2'b11) ? 2'b00 : sz;
        mem = rd | wr;
        mis = mem && ((s == 2'b01 && alu[0]) || (s == 2'b00 && alu[1:0] != 2'b00));
        e.pc = $urandom; e.instr = $urandom; e.alu = alu; e.wreg = wreg;
        e.mis = mis; e.rdata = 32'd0; e.wb = mis ? 1'b0 : wb;
        e.due = cyc + 1;
        ns = 0;
        if (mem && !mis) begin
            nb   = (s == 2'b10) ? 1 : (s == 2'b01) ? 2 : 4;
            base = int'(alu[5:0]);
            if (wr) begin
                for (int i = 0; i < nb; i++) mdl[(base + i) % NB] = d2[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[(base + i) % NB];
                if (sx && nb < 4 && v[8*nb-1])
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                e.rdata = v;
            end
            ns    = LAT;
            e.due = cyc + LAT + 1;
        end
        q.push_back(e);
        m_currPC = e.pc; m_instruction = e.instr; m_memRead = rd; m_memWrite = wr;
        m_size = sz; m_signExt = sx; m_writeBack = wb; m_writeReg = wreg;
        m_ALUresult = alu; m_data2 = d2;
        n = 0;
        @(negedge Clk);
        while (stall === 1'b1 && n < 20) begin
            n++;
            @(negedge Clk);
        end
        check("stall_cycles", 32'(n), 32'(ns));
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_nop();
        m_currPC = 32'd0; m_instruction = 32'd0; m_memRead = 1'b0; m_memWrite = 1'b0;
        m_size = 2'b00; m_signExt = 1'b0; m_writeBack = 1'b0; m_writeReg = 5'd0;
        m_ALUresult = 32'd0; m_data2 = 32'd0;
    endtask

    initial begin : stim
        int          n;
        logic        rd, wr;
        logic [1:0]  sz;
        logic [31:0] a;
        Rst = 1'b1;
        drive_nop();
        started = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;

        for (int w = 0; w < NB / 4; w++) issue(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'(4 * w), $urandom);

        // Word store then load
        issue(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd3, 32'h10, 32'd0);
        // Byte store, signed/unsigned byte loads, untouched lanes
        issue(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 32'h13, 32'h00000080);
        issue(1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 5'd4, 32'h13, 32'd0);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd4, 32'h13, 32'd0);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd4, 32'h10, 32'd0);
        // Misaligned half load, then confirm memory intact
        issue(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd6, 32'h11, 32'd0);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd6, 32'h10, 32'd0);
        // Load followed back-to-back by a non-memory op
        issue(1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 5'd2, 32'h12, 32'd0);
        issue(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 32'd7, 32'd0);

        // Reset in the first BUSY cycle of a store to 0x20
        m_currPC = $urandom; m_instruction = $urandom; m_memRead = 1'b0; m_memWrite = 1'b1;
        m_size = 2'b00; m_signExt = 1'b0; m_writeBack = 1'b0; m_writeReg = 5'd0;
        m_ALUresult = 32'h20; m_data2 = 32'h12345678;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        drive_nop();
        #1;
        check("stall_in_reset", {31'd0, stall}, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd7, 32'h20, 32'd0);

        // Address wrap, size 11 as word, read+write as store only
        issue(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 32'h4, 32'hAAAA5555);
        issue(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 5'd0, 32'(4 + NB), 32'h0BADF00D);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd8, 32'h4, 32'd0);
        issue(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 5'd9, 32'h8, 32'hFFFF8001);
        issue(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 5'd9, 32'h8, 32'd0);

        for (int k = 0; k < 150; k++) begin
            n  = int'($urandom_range(0, 9));
            rd = (n >= 3 && n <= 5) || n == 9;
            wr = (n >= 6);
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 2 * NB - 1)) | {$urandom_range(0, 1) == 0 ? 24'd0 : 24'hABCDE0, 8'd0};
            if ($urandom_range(0, 3) != 0)
                a = (sz == 2'b10) ? a : (sz == 2'b01) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
            issue(rd, wr, sz, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), a, $urandom);
        end

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (q.size() != 0) check("scoreboard_drain", 32'(q.size()), 32'd0);
        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, word-address width (DEPTH = 2^ADDR_BITS words of 32 bits).
REQ-002 SHALL have parameter LATENCY, default 2, memory wait cycles per access (legal range 1..15).
REQ-003 SHALL use one clock; reset is synchronous and active-high; ports named Clk and Rst.
REQ-004 SHALL have these ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous active-high reset.
- m_currPC  in  32  PC of the instruction in MEM.
- m_instruction  in  32  instruction word.
- m_memRead  in  1  load request.
- m_memWrite  in  1  store request.
- m_size  in  2  access size: 00 word, 01 half, 10 byte; 11 is treated as word.
- m_signExt  in  1  sign-extend a byte/half load.
- m_writeBack  in  1  register-write enable.
- m_writeReg  in  5  destination register.
- m_ALUresult  in  32  byte address or pass-through result.
- m_data2  in  32  store data.
- stall  out  1  hold request to upstream stages.
- w_currPC, w_instruction, w_ALUresult, w_readData  out  32  MEM/WB outputs.
- w_writeBack  out  1  MEM/WB register-write enable.
- w_writeReg  out  5  MEM/WB destination register.
- w_misaligned  out  1  one-cycle fault pulse.

Function
REQ-005 SHALL implement an FSM with states IDLE and BUSY, plus a 4-bit wait counter cnt.
REQ-006 In IDLE with no memory request, SHALL register all m_* fields into w_* on the next edge, load w_readData=0, and keep stall=0.
REQ-007 In IDLE with an aligned request, SHALL assert stall combinationally in the same cycle.
REQ-008 On that same edge (REQ-007), SHALL latch address, data, size, signExt, writeBack, writeReg, PC and instruction; set cnt=LATENCY-1; go to BUSY; load w_writeBack=0 (bubble).
REQ-009 In BUSY with cnt>0, SHALL keep stall=1, decrement cnt, and hold w_writeBack=0.
REQ-010 In BUSY with cnt=0, SHALL drive stall=0, perform the access on that edge, load w_* from the latched fields, and return to IDLE.
REQ-011 A memory operation SHALL take LATENCY+1 cycles from presentation to w_* update; a non-memory operation SHALL take 1 cycle.
REQ-012 While stall=1, upstream holds m_* stable; the block SHALL use only latched values in BUSY.
REQ-013 Memory SHALL be little-endian, indexed by address[ADDR_BITS+1:2]; upper address bits are ignored (address wraps).
REQ-014 Stores SHALL write through byte enables: a byte store writes lane address[1:0] from data2[7:0]; a half store writes lanes {address[1],0}+{0,1} from data2[15:0]; a word store writes all lanes; other lanes are unchanged.
REQ-015 Loads SHALL extract the addressed lane(s) and sign-extend when m_signExt=1, otherwise zero-extend; a word load returns the word unmodified.
REQ-016 A misaligned request (half with address[0]=1, word with address[1:0]!=0) SHALL cause no access and no stall; in one cycle, w_misaligned=1, w_writeBack=0, and w_readData=0.
REQ-017 If m_memRead and m_memWrite are both 1, the block SHALL perform the store only and set w_readData=0.
REQ-018 w_misaligned SHALL be 0 in every cycle other than the one following a misaligned request.

Reset
REQ-019 While Rst=1, on each edge: state=IDLE, cnt=0, and all w_* outputs=0.
REQ-020 stall SHALL be forced to 0 combinationally while Rst=1.
REQ-021 Reset during BUSY SHALL abort the operation; a pending store SHALL NOT be written.
REQ-022 Memory contents SHALL NOT be reset.

Structure
REQ-023 A shared package SHALL hold the size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and the FSM state encodings.
REQ-024 Storage SHALL be a sub-module data_memory: word array, 4-bit byte-enable synchronous write, asynchronous word read.
REQ-025 The FSM, lane formatting and MEM/WB output registers SHALL reside in mem_access_unit.

Verification
REQ-026 Scenario 1: Word store 0xDEADBEEF to 0x10, then word load from 0x10 with LATENCY=2 -> stall high 2 cycles per op; w_readData=0xDEADBEEF at cycle 3 of the load.
REQ-027 Scenario 2: Byte store 0x80 to 0x13, then byte load from 0x13 -> signExt=1 gives 0xFFFFFF80; signExt=0 gives 0x00000080; lanes 0..2 of word 0x10 are unchanged.
REQ-028 Scenario 3: Half load from 0x11 -> w_misaligned=1 for 1 cycle, w_writeBack=0, stall never asserted, memory unchanged.
REQ-029 Scenario 4: Non-memory op (writeReg=5, ALUresult=7) follows a load back-to-back -> w_ALUresult=7 appears exactly 1 cycle after the load result, with w_writeBack=1.
REQ-030 Scenario 5: Rst asserted in the first BUSY cycle of a store to 0x20 -> a subsequent load from 0x20 returns the pre-store value, and all w_*=0 during reset.
REQ-031 Scenario 6: Store to 0x4 and to 0x4+4*DEPTH -> the second store overwrites the first (address wrap).
